// File: rtl/key_cond_pkg.sv
// Shared constants and helpers for the key conditioning stage.
package key_cond_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;

  // Debounce counter width: max(1, clog2(n)).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, stable level,
// registered press/release pulses and a toggle state. Input is normalised
// (1 = pressed).
module key_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;

  // Two-flop synchroniser; nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after an uninterrupted run of mismatching samples.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d  = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
        toggle_d  = toggle_q ^ sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw push-button pins into clean synchronous level, pulse and
// toggle signals, one independent channel per key.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned KEY_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle
);

  logic [NUM_KEYS-1:0] key_norm;

  // Normalise polarity so that 1 always means pressed.
  assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  // One debounce channel per key.
  for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_i    (key_norm[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .toggle_o (key_toggle[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (DEBOUNCE_CYCLES = 4, active-low keys).
module tb_key_conditioner;
  import key_cond_pkg::*;

  localparam int unsigned NK = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level, key_press, key_release, key_toggle;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  // Segment: raw held for n cycles, outputs expected constant on each of them.
  typedef struct {
    logic [2:0]  raw;
    int unsigned n;
    logic [2:0]  lvl, prs, rel, tgl;
  } vec_t;

  typedef struct {
    logic [2:0] lvl, prs, rel, tgl;
    string      tag;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic add(input logic [2:0] raw, input int unsigned n,
                     input logic [2:0] lvl, input logic [2:0] prs,
                     input logic [2:0] rel, input logic [2:0] tgl);
    vec_t v;
    v.raw = raw; v.n = n; v.lvl = lvl; v.prs = prs; v.rel = rel; v.tgl = tgl;
    vecs.push_back(v);
  endtask

  task automatic check_now(input string name, input logic [2:0] lvl,
                           input logic [2:0] prs, input logic [2:0] rel,
                           input logic [2:0] tgl);
    n_checks++;
    if ({key_level, key_press, key_release, key_toggle} === {lvl, prs, rel, tgl})
      n_pass++;
    else
      $display("FAIL %s: got lvl=%b prs=%b rel=%b tgl=%b, want lvl=%b prs=%b rel=%b tgl=%b",
               name, key_level, key_press, key_release, key_toggle, lvl, prs, rel, tgl);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic cyc(input logic [2:0] raw, input logic [2:0] lvl,
                     input logic [2:0] prs, input logic [2:0] rel,
                     input logic [2:0] tgl, input string tag);
    exp_t e;
    key_raw = raw;
    e.lvl = lvl; e.prs = prs; e.rel = rel; e.tgl = tgl; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb_q.pop_front();
      check_now(e.tag, e.lvl, e.prs, e.rel, e.tgl);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    key_raw = 3'b111;
    #3;
    check_now("reset_initial", 3'b000, 3'b000, 3'b000, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_held", 3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    //   raw     n   lvl     prs     rel     tgl
    add(3'b111,  4, 3'b000, 3'b000, 3'b000, 3'b000); // idle
    // clean press key0, then release; second press/release
    add(3'b110,  5, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b110,  1, 3'b001, 3'b001, 3'b000, 3'b001);
    add(3'b110, 10, 3'b001, 3'b000, 3'b000, 3'b001);
    add(3'b111,  5, 3'b001, 3'b000, 3'b000, 3'b001);
    add(3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b001);
    add(3'b111, 10, 3'b000, 3'b000, 3'b000, 3'b001);
    add(3'b110,  5, 3'b000, 3'b000, 3'b000, 3'b001);
    add(3'b110,  1, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b110, 10, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b111,  5, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b000);
    add(3'b111,  6, 3'b000, 3'b000, 3'b000, 3'b000);
    // bounce on key1: low 3, high 1, low held
    add(3'b101,  3, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b111,  1, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b101,  5, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b101,  1, 3'b010, 3'b010, 3'b000, 3'b010);
    add(3'b101,  5, 3'b010, 3'b000, 3'b000, 3'b010);
    add(3'b111,  5, 3'b010, 3'b000, 3'b000, 3'b010);
    add(3'b111,  1, 3'b000, 3'b000, 3'b010, 3'b010);
    add(3'b111,  4, 3'b000, 3'b000, 3'b000, 3'b010);
    // glitch on key2: low for only 3 samples
    add(3'b011,  3, 3'b000, 3'b000, 3'b000, 3'b010);
    add(3'b111,  8, 3'b000, 3'b000, 3'b000, 3'b010);
    // keys 0 and 2 together
    add(3'b010,  5, 3'b000, 3'b000, 3'b000, 3'b010);
    add(3'b010,  1, 3'b101, 3'b101, 3'b000, 3'b111);
    add(3'b010,  5, 3'b101, 3'b000, 3'b000, 3'b111);
    add(3'b111,  5, 3'b101, 3'b000, 3'b000, 3'b111);
    add(3'b111,  1, 3'b000, 3'b000, 3'b101, 3'b111);
    add(3'b111,  4, 3'b000, 3'b000, 3'b000, 3'b111);

    foreach (vecs[i]) begin
      for (int c = 0; c < int'(vecs[i].n); c++)
        cyc(vecs[i].raw, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].tgl,
            $sformatf("vec%0d.%0d", i, c));
    end

    // Reset asserted mid-count with key0 held low: clears at once, mid-cycle.
    for (int c = 0; c < 3; c++)
      cyc(3'b110, 3'b000, 3'b000, 3'b000, 3'b111, $sformatf("midcount.%0d", c));
    #2;
    rst_n = 1'b0;
    #1;
    check_now("reset_midcount_async", 3'b000, 3'b000, 3'b000, 3'b000);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_now($sformatf("reset_midcount_hold.%0d", c), 3'b000, 3'b000, 3'b000, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Key still held after reset: detected as a fresh press, no exit pulse.
    for (int c = 0; c < 5; c++)
      cyc(3'b110, 3'b000, 3'b000, 3'b000, 3'b000, $sformatf("held_wait.%0d", c));
    cyc(3'b110, 3'b001, 3'b001, 3'b000, 3'b001, "held_press");
    for (int c = 0; c < 3; c++)
      cyc(3'b110, 3'b001, 3'b000, 3'b000, 3'b001, $sformatf("held_after.%0d", c));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
